// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file; one-hot decode feeds both write enables and the scoreboard.
// Combinational helpers only, no state; nothing here stalls.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Decode is sized for the largest supported file; callers truncate to NREGS.
  localparam int NREGS_MAX = 1024;
  localparam int AW_MAX    = $clog2(NREGS_MAX);

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

  function automatic logic [NREGS_MAX-1:0] onehot_dec(input logic [AW_MAX-1:0] addr);
    logic [NREGS_MAX-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write ports, read ports, issue/flush and scoreboard status (wr_conflict only with REGFILE_WR_CONFLICT_CHK_EN).
// Reads are zero latency; there is no backpressure, stalling is the hazard unit's job using rd_busy/busy_vec.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 7,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     flush;
  logic [NREGS-1:0]         busy_vec;
`ifdef REGFILE_WR_CONFLICT_CHK_EN
  logic                     wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_vec, wr_conflict
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_vec, wr_conflict
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
`endif

endinterface

// File: rtl/regfile_scoreboard.sv
// Single-level pending bit per register: set on issue, cleared on writeback, flush clears all; rd_busy is masked by same-cycle writeback.
// Pending updates on the next edge, rd_busy is combinational; no backpressure of its own.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 7,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_iss_en,
  input  logic [AW-1:0]          i_iss_addr,
  input  logic                   i_flush,
  input  logic [NWR-1:0]         i_wr_en,
  input  logic [NWR-1:0][AW-1:0] i_wr_addr,
  input  logic [NRD-1:0][AW-1:0] i_rd_addr,
  output logic [NRD-1:0]         o_rd_busy,
  output logic [NREGS-1:0]       o_busy_vec
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_pend_nxt;
  logic [NRD-1:0]   w_rd_busy;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_iss_en && !(ZERO_REG != 0 && i_iss_addr == '0))
      w_set = NREGS'(onehot_dec(AW_MAX'(i_iss_addr)));
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p])
        w_clr = w_clr | NREGS'(onehot_dec(AW_MAX'(i_wr_addr[p])));
    end
    // A younger producer issued in the writeback cycle keeps the bit set.
    w_pend_nxt = i_flush ? '0 : ((r_pend & ~w_clr) | w_set);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_pend <= '0;
    else
      r_pend <= w_pend_nxt;
  end

  always_comb begin
    w_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rd_busy[i] = r_pend[i_rd_addr[i]] & ~w_clr[i_rd_addr[i]];
      if (ZERO_REG != 0 && i_rd_addr[i] == '0)
        w_rd_busy[i] = 1'b0;
    end
  end

  assign o_rd_busy  = w_rd_busy;
  assign o_busy_vec = r_pend;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write integer register file with write-through bypass and pending scoreboard; REGFILE_WR_CONFLICT_CHK_EN adds a sticky write-collision flag.
// Reads combinational (zero latency), writes land on the next edge; never backpressures.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 7,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic       clk,
  input  logic       reset_n,
  regfile_mp_if.slave bus
);

  logic [XLEN-1:0]           r_rf [NREGS];
  logic [NWR-1:0][NREGS-1:0] w_wdec;
  logic [NREGS-1:0]          w_we;
  logic [XLEN-1:0]           w_wd [NREGS];
  logic [NRD-1:0][XLEN-1:0]  w_rd_data;

  // Later ports overwrite earlier ones so the highest index wins a collision.
  always_comb begin
    for (int p = 0; p < NWR; p++)
      w_wdec[p] = bus.wr_en[p] ? NREGS'(onehot_dec(AW_MAX'(bus.wr_addr[p]))) : '0;
    for (int r = 0; r < NREGS; r++) begin
      w_we[r] = 1'b0;
      w_wd[r] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (w_wdec[p][r]) begin
          w_we[r] = 1'b1;
          w_wd[r] = bus.wr_data[p];
        end
      end
    end
    if (ZERO_REG != 0)
      w_we[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++)
        r_rf[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (w_we[r])
          r_rf[r] <= w_wd[r];
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rd_data[i] = r_rf[bus.rd_addr[i]];
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p] && bus.wr_addr[p] == bus.rd_addr[i])
          w_rd_data[i] = bus.wr_data[p];
      end
      if (ZERO_REG != 0 && bus.rd_addr[i] == '0)
        w_rd_data[i] = '0;
    end
  end

  assign bus.rd_data = w_rd_data;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .i_flush    (bus.flush),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_rd_addr  (bus.rd_addr),
    .o_rd_busy  (bus.rd_busy),
    .o_busy_vec (bus.busy_vec)
  );

`ifdef REGFILE_WR_CONFLICT_CHK_EN
  logic r_wr_conflict;
  logic w_conflict;

  always_comb begin
    w_conflict = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (bus.wr_en[p] && bus.wr_en[q] && bus.wr_addr[p] == bus.wr_addr[q] &&
            !(ZERO_REG != 0 && bus.wr_addr[p] == '0))
          w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_wr_conflict <= 1'b0;
    else if (w_conflict)
      r_wr_conflict <= 1'b1;
  end

  assign bus.wr_conflict = r_wr_conflict;
`endif

endmodule
